// File: rtl/truth_table_scanner.sv
// ---------------------------------------------------------------------------
// truth_table_scanner
//
// Purpose:
//   Sequencer and capture stage wrapped around a combinational N-input logic
//   cell. On start it walks the cell inputs through every vector 0..2^N-1 in
//   ascending order. Each vector is held for SETTLE_CYCLES cycles before the
//   cell output is sampled. The samples are assembled into a 2^N-bit minterm
//   mask, and the minterms are counted alongside.
//
// Parameters:
//   N_INPUTS       number of cell inputs; mask width is 2^N_INPUTS
//   SETTLE_CYCLES  cycles each vector is held before sampling (>= 1)
//
// Ports:
//   clk       rising-edge clock
//   reset     synchronous, active-high reset
//   start     begin a scan (accepted only when idle or done)
//   abort     cancel a scan in progress
//   s_in      output of the logic cell under scan
//   vec       drive to the cell; vec[N-1] is the MSB input
//   busy      high while a scan is in progress
//   done      one-cycle pulse when mask/ones_cnt are final
//   mask      mask[i] = s_in sampled while vec == i
//   ones_cnt  number of 1 bits in mask
// ---------------------------------------------------------------------------
module truth_table_scanner #(
  parameter int N_INPUTS      = 3,
  parameter int SETTLE_CYCLES = 1
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       start,
  input  logic                       abort,
  input  logic                       s_in,
  output logic [N_INPUTS-1:0]        vec,
  output logic                       busy,
  output logic                       done,
  output logic [(1<<N_INPUTS)-1:0]   mask,
  output logic [N_INPUTS:0]          ones_cnt
);

  // The settle counter only ever needs to reach SETTLE_CYCLES-1 before the
  // sample step; it is reloaded on every new vector, so any overflow past
  // that value is never observed.
  localparam int CNT_W = (SETTLE_CYCLES > 1) ? $clog2(SETTLE_CYCLES) : 1;
  localparam logic [CNT_W-1:0]    CNT_LAST = CNT_W'(SETTLE_CYCLES - 1);
  localparam logic [N_INPUTS-1:0] IDX_LAST = '1;

  typedef enum logic [1:0] {
    IDLE,
    DRIVE,
    SAMPLE,
    DONE
  } state_t;

  state_t               state;
  logic [N_INPUTS-1:0]  index;
  logic [CNT_W-1:0]     settle_cnt;

  // The cell is driven straight from the scan index, so vec is registered
  // and stays stable through the whole DRIVE/SAMPLE period of one vector.
  assign vec = index;

  // Single sequencer process. Abort is handled ahead of the per-state logic
  // so it beats both a pending sample write and any start request; abort
  // outside a scan falls through to the state logic and does nothing there.
  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= IDLE;
      index      <= '0;
      settle_cnt <= '0;
      busy       <= 1'b0;
      done       <= 1'b0;
      mask       <= '0;
      ones_cnt   <= '0;
    end else if (abort && (state == DRIVE || state == SAMPLE)) begin
      state      <= IDLE;
      index      <= '0;
      settle_cnt <= '0;
      busy       <= 1'b0;
      done       <= 1'b0;
      mask       <= '0;
      ones_cnt   <= '0;
    end else begin
      case (state)
        IDLE, DONE: begin
          done <= 1'b0;
          if (start) begin
            state      <= DRIVE;
            busy       <= 1'b1;
            index      <= '0;
            settle_cnt <= '0;
            mask       <= '0;
            ones_cnt   <= '0;
          end
        end

        DRIVE: begin
          settle_cnt <= settle_cnt + 1'b1;
          if (settle_cnt == CNT_LAST) begin
            state <= SAMPLE;
          end
        end

        SAMPLE: begin
          mask[index] <= s_in;
          ones_cnt    <= ones_cnt + {{N_INPUTS{1'b0}}, s_in};
          // The last vector ends the scan instead of wrapping the index.
          if (index == IDX_LAST) begin
            state <= DONE;
            busy  <= 1'b0;
            done  <= 1'b1;
          end else begin
            state      <= DRIVE;
            index      <= index + 1'b1;
            settle_cnt <= '0;
          end
        end

        default: begin
          state <= IDLE;
          busy  <= 1'b0;
          done  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_truth_table_scanner.sv
// ---------------------------------------------------------------------------
// tb_truth_table_scanner
//
// Purpose:
//   Self-checking bench for truth_table_scanner. Two instances run side by
//   side on the same controls and the same cell function: u0 with the
//   default one-cycle settle time and u1 with a three-cycle settle time.
//   The cell is modelled as an 8-entry truth table (func) indexed by vec.
// ---------------------------------------------------------------------------
module tb_truth_table_scanner;

  localparam int NV = 8;

  logic       clk = 1'b0;
  logic       reset;
  logic       start;
  logic       abort;
  logic [7:0] func;

  logic [2:0] vec0, vec1;
  logic       busy0, busy1, done0, done1;
  logic [7:0] mask0, mask1;
  logic [3:0] ones0, ones1;
  logic       s_in0, s_in1;

  int total = 0;
  int bad   = 0;

  // Behavioural model state, one entry per instance.
  bit         m_act[2];
  int         m_elapsed[2];
  int         m_vec[2];
  logic [7:0] m_mask[2];
  int         m_ones[2];
  bit         m_busy[2];
  bit         m_done[2];

  // Free-running clock, 10 time units per period.
  always #5 clk = ~clk;

  // The cell under scan is simply a lookup into the current truth table.
  assign s_in0 = func[vec0];
  assign s_in1 = func[vec1];

  truth_table_scanner u0 (
    .clk      (clk),
    .reset    (reset),
    .start    (start),
    .abort    (abort),
    .s_in     (s_in0),
    .vec      (vec0),
    .busy     (busy0),
    .done     (done0),
    .mask     (mask0),
    .ones_cnt (ones0)
  );

  truth_table_scanner #(.N_INPUTS(3), .SETTLE_CYCLES(3)) u1 (
    .clk      (clk),
    .reset    (reset),
    .start    (start),
    .abort    (abort),
    .s_in     (s_in1),
    .vec      (vec1),
    .busy     (busy1),
    .done     (done1),
    .mask     (mask1),
    .ones_cnt (ones1)
  );

  function automatic int settle_of(input int u);
    return (u == 0) ? 1 : 3;
  endfunction

  // Single comparison point: counts the check and reports any mismatch.
  task automatic checkOutput(input string name, input int actual, input int expected);
    total++;
    if (actual !== expected) begin
      bad++;
      $display("[TB] FAIL %s: got %0d, expected %0d (t=%0t)", name, actual, expected, $time);
    end
  endtask

  // Inputs change on the falling edge so they are stable at the next rising edge.
  task automatic applyStimulus(input logic r, input logic st, input logic ab);
    @(negedge clk);
    reset = r;
    start = st;
    abort = ab;
  endtask

  // Advances the model by one clock edge. A scan is described only by how
  // many cycles have elapsed since its start edge: each vector takes
  // settle+1 cycles, a vector's bit lands when its slot is complete, and
  // the scan finishes after all eight slots.
  task automatic model_step(input int u);
    int p;
    int v;
    p = settle_of(u) + 1;
    if (reset) begin
      m_act[u] = 0; m_elapsed[u] = 0; m_vec[u] = 0;
      m_mask[u] = '0; m_ones[u] = 0; m_busy[u] = 0; m_done[u] = 0;
    end else if (m_act[u]) begin
      if (abort) begin
        m_act[u] = 0; m_elapsed[u] = 0; m_vec[u] = 0;
        m_mask[u] = '0; m_ones[u] = 0; m_busy[u] = 0; m_done[u] = 0;
      end else begin
        m_elapsed[u]++;
        if (m_elapsed[u] % p == 0) begin
          v = m_elapsed[u] / p - 1;
          m_mask[u][v] = func[v];
          m_ones[u] = $countones(m_mask[u]);
        end
        if (m_elapsed[u] == NV * p) begin
          m_act[u] = 0; m_busy[u] = 0; m_done[u] = 1;
        end else begin
          m_vec[u] = m_elapsed[u] / p; m_busy[u] = 1; m_done[u] = 0;
        end
      end
    end else begin
      m_done[u] = 0;
      if (start) begin
        m_act[u] = 1; m_elapsed[u] = 0; m_vec[u] = 0;
        m_mask[u] = '0; m_ones[u] = 0; m_busy[u] = 1;
      end
    end
  endtask

  task automatic check_unit(input int u, input int vec, input int busy, input int done,
                            input int mask, input int ones);
    checkOutput($sformatf("u%0d.vec", u),  vec,  m_vec[u]);
    checkOutput($sformatf("u%0d.busy", u), busy, int'(m_busy[u]));
    checkOutput($sformatf("u%0d.done", u), done, int'(m_done[u]));
    checkOutput($sformatf("u%0d.mask", u), mask, int'(m_mask[u]));
    checkOutput($sformatf("u%0d.ones_cnt", u), ones, m_ones[u]);
    checkOutput($sformatf("u%0d.busy_and_done", u), busy & done, 0);
  endtask

  // Compare process: the model consumes the same inputs the DUTs see at
  // each rising edge, then both instances are checked just after the edge.
  always @(posedge clk) begin
    model_step(0);
    model_step(1);
    #1;
    check_unit(0, vec0, busy0, done0, mask0, ones0);
    check_unit(1, vec1, busy1, done1, mask1, ones1);
  end

  // Waits (bounded) for u1's done pulse; u1 is the slower instance.
  task automatic wait_done1(output int n);
    n = 0;
    while (!done1 && n < 100) begin
      @(posedge clk);
      n++;
      #1;
    end
    checkOutput("wait_done1.timeout", int'(done1), 1);
  endtask

  // Full scan with fixed latency and final-value expectations.
  task automatic scan_check(input logic [7:0] f, input int exp_mask, input int exp_ones);
    int n;
    int n0;
    int n1;
    @(negedge clk);
    func  = f;
    reset = 1'b0;
    abort = 1'b0;
    start = 1'b1;
    @(posedge clk);
    #1;
    checkOutput("start.mask0_cleared", int'(mask0), 0);
    checkOutput("start.ones0_cleared", int'(ones0), 0);
    checkOutput("start.busy0", int'(busy0), 1);
    @(negedge clk);
    start = 1'b0;
    n = 0; n0 = -1; n1 = -1;
    while (n1 < 0 && n < 100) begin
      @(posedge clk);
      n++;
      #1;
      if (done0 && n0 < 0) n0 = n;
      if (done1 && n1 < 0) n1 = n;
    end
    checkOutput("latency.u0", n0, 16);
    checkOutput("latency.u1", n1, 32);
    checkOutput("final.mask0", int'(mask0), exp_mask);
    checkOutput("final.ones0", int'(ones0), exp_ones);
    checkOutput("final.mask1", int'(mask1), exp_mask);
    checkOutput("final.ones1", int'(ones1), exp_ones);
    checkOutput("model.mask0", int'(m_mask[0]), exp_mask);
    checkOutput("model.ones1", m_ones[1], exp_ones);
  endtask

  // Main stimulus sequence: directed scenarios first, then random traffic.
  initial begin
    int k;
    int n;
    reset = 1'b1;
    start = 1'b0;
    abort = 1'b0;
    func  = 8'h00;

    applyStimulus(1, 0, 0);
    applyStimulus(1, 0, 0);
    applyStimulus(0, 0, 0);
    checkOutput("reset.vec0",  int'(vec0),  0);
    checkOutput("reset.mask0", int'(mask0), 0);
    checkOutput("reset.ones1", int'(ones1), 0);
    checkOutput("reset.busy1", int'(busy1), 0);

    $display("[TB] sum-of-products cell");
    scan_check(8'hC6, 8'hC6, 4);
    $display("[TB] constant cells");
    scan_check(8'hFF, 8'hFF, 8);
    scan_check(8'h00, 8'h00, 0);
    $display("[TB] three-input xor cell");
    scan_check(8'h96, 8'h96, 4);

    $display("[TB] abort mid-scan");
    func = 8'hC6;
    applyStimulus(0, 1, 0);
    applyStimulus(0, 0, 0);
    k = 0;
    while (vec0 != 3'd5 && k < 100) begin
      @(negedge clk);
      k++;
    end
    checkOutput("abort.reached_vec5", int'(vec0), 5);
    abort = 1'b1;
    applyStimulus(0, 0, 0);
    checkOutput("abort.vec0",  int'(vec0),  0);
    checkOutput("abort.mask0", int'(mask0), 0);
    checkOutput("abort.busy0", int'(busy0), 0);
    checkOutput("abort.done0", int'(done0), 0);
    repeat (4) applyStimulus(0, 0, 0);
    scan_check(8'hC6, 8'hC6, 4);

    $display("[TB] reset mid-scan, start while busy");
    applyStimulus(0, 1, 0);
    applyStimulus(0, 0, 0);
    k = 0;
    while (vec0 != 3'd3 && k < 100) begin
      @(negedge clk);
      k++;
    end
    checkOutput("reset_mid.reached_vec3", int'(vec0), 3);
    reset = 1'b1;
    applyStimulus(0, 0, 0);
    checkOutput("reset_mid.vec0",  int'(vec0),  0);
    checkOutput("reset_mid.mask1", int'(mask1), 0);
    checkOutput("reset_mid.busy0", int'(busy0), 0);
    func = 8'h5A;
    applyStimulus(0, 1, 0);
    applyStimulus(0, 0, 0);
    repeat (5) applyStimulus(0, 0, 0);
    applyStimulus(0, 1, 0);
    applyStimulus(0, 0, 0);
    wait_done1(n);
    checkOutput("busy_start.mask0", int'(mask0), 8'h5A);
    checkOutput("busy_start.mask1", int'(mask1), 8'h5A);

    $display("[TB] restart from done, start with abort in idle");
    scan_check(8'h5A, 8'h5A, 4);
    applyStimulus(1, 0, 0);
    applyStimulus(0, 1, 1);
    @(posedge clk);
    #1;
    checkOutput("start_abort_idle.busy0", int'(busy0), 1);
    checkOutput("start_abort_idle.busy1", int'(busy1), 1);
    applyStimulus(0, 0, 0);
    wait_done1(n);
    checkOutput("start_abort_idle.mask0", int'(mask0), 8'h5A);

    $display("[TB] random traffic");
    for (int i = 0; i < 600; i++) begin
      @(negedge clk);
      reset = ($urandom_range(0, 59) == 0);
      start = ($urandom_range(0, 5) == 0);
      abort = ($urandom_range(0, 39) == 0);
      if ($urandom_range(0, 15) == 0) func = 8'($urandom);
    end
    applyStimulus(0, 0, 0);
    applyStimulus(0, 0, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
